// File: rtl/mem_arb_pkg.sv
// Shared types for the rotating-priority memory arbiter and its client ports.
// Optional starvation timeout in mem_client_port: define MEM_CLIENT_TIMEOUT_EN.
package mem_arb_pkg;

    localparam int MEM_PORTS = 16;
    localparam int MEM_AW    = 16;
    localparam int MEM_DW    = 32;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } client_state_e;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous show-ahead command FIFO; head entry is visible combinationally.
// No bypass: a full FIFO refuses writes even when a read happens the same cycle.
import mem_arb_pkg::*;

module mem_cmd_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = mem_cmd_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  T                       wr_data,
    input  logic                   rd_en,
    output T                       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [PW-1:0]  wp;
    logic [PW-1:0]  rp;
    logic [PW:0]    cnt;
    logic           push;
    logic           pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem[rp];

    // Storage array; contents need no reset, pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_client_port.sv
// Requester side of the shared-memory arbiter: buffers, requests, issues, returns reads.
// Define MEM_CLIENT_TIMEOUT_EN to enable the sticky req-without-gnt starvation flag.
import mem_arb_pkg::*;

module mem_client_port #(
    parameter int DEPTH   = 4,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          req,
    input  logic          gnt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          timeout_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    client_state_e      state;
    client_state_e      state_nx;
    cmd_t               wr_cmd;
    cmd_t               head;
    logic               full;
    logic               empty;
    logic [CW-1:0]      count;
    logic               push;
    logic               issue;
    logic [RD_LAT-1:0]  rd_pipe;

    assign wr_cmd    = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    assign issue     = (state == REQ) & gnt;

    mem_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (cmd_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cmd_valid),
        .wr_data (wr_cmd),
        .rd_en   (issue),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Request while the FIFO will hold anything after this edge.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (!empty || push) state_nx = REQ;
            REQ:  if (issue && count == CW'(1) && !push) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus drive: head of FIFO only during the issue cycle, zero otherwise.
    always_comb begin
        req       = (state == REQ);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            mem_en    = 1'b1;
            mem_we    = head.we;
            mem_addr  = head.addr;
            mem_wdata = head.wdata;
        end
    end

    // Read-return tracker: one bit per outstanding read, aged each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= issue & ~head.we;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rsp_valid = rd_pipe[RD_LAT-1];
    assign rsp_rdata = mem_rdata;

`ifdef MEM_CLIENT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          to_err_q;
    logic          to_hit;

    assign to_hit = (state == REQ) & ~gnt & (to_cnt == TW'(TIMEOUT - 1));

    // Count ungranted request cycles; flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (state != REQ || gnt) begin
                to_cnt <= '0;
            end else if (to_cnt != TW'(TIMEOUT)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_hit) to_err_q <= 1'b1;
        end
    end

    assign timeout_err = to_err_q | to_hit;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_client_port.sv
// Scoreboard bench for mem_client_port: directed stimulus, queued read expectations.
// Timeout scenario is exercised when MEM_CLIENT_TIMEOUT_EN is defined.
module tb_mem_client_port;

    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          req;
    logic          gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          timeout_err;

    logic gnt_tie;
    logic gnt_rot;
    logic gnt_drv;
    int   cyc;

    int            checks;
    int            passes;
    int            rsp_cnt;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign gnt = gnt_tie ? req :
                 gnt_rot ? (req & (cyc[3:0] == 4'd0)) :
                 gnt_drv;

    mem_client_port #(
        .DEPTH   (4),
        .AW      (AW),
        .DW      (DW),
        .RD_LAT  (RD_LAT),
        .TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .req         (req),
        .gnt         (gnt),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .timeout_err (timeout_err)
    );

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        return {16'hC0DE, a};
    endfunction

    // Memory model: read data appears two cycles after the issue cycle.
    logic          st0_v;
    logic          st1_v;
    logic [AW-1:0] st0_a;
    logic [AW-1:0] st1_a;

    always @(posedge clk) begin
        st0_v <= mem_en & ~mem_we;
        st0_a <= mem_addr;
        st1_v <= st0_v;
        st1_a <= st0_a;
    end

    assign mem_rdata = st1_v ? rd_model(st1_a) : '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Response monitor: every rsp_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
            else check("rsp_rdata", 64'(rsp_rdata), 64'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        check("push_ready", 64'(cmd_ready), 64'd1);
        if (!we) exp_q.push_back(rd_model(a));
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        checks = 0; passes = 0; rsp_cnt = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
        cmd_addr = '0; cmd_wdata = '0;
        gnt_tie = 1'b0; gnt_rot = 1'b0; gnt_drv = 1'b0;
        step(); step();
        rst = 1'b0;
        smp();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_req", 64'(req), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);

        // Single read with gnt tied to req.
        step();
        gnt_tie = 1'b1;
        push(1'b0, 16'h0010, '0);
        smp();
        check("t1_req", 64'(req), 64'd1);
        check("t1_mem_en", 64'(mem_en), 64'd1);
        check("t1_mem_addr", 64'(mem_addr), 64'h10);
        check("t1_mem_we", 64'(mem_we), 64'd0);
        step(); smp();
        check("t1_rsp_early", 64'(rsp_valid), 64'd0);
        check("t1_req_drop", 64'(req), 64'd0);
        step(); smp();
        check("t1_rsp_lat", 64'(rsp_valid), 64'd1);
        step();
        gnt_tie = 1'b0;

        // Fill with writes, stall a fifth, then drain back to back.
        for (int i = 0; i < 4; i++) begin
            push(1'b1, AW'(16'h0100 + i), DW'(32'hA000_0000 + i));
        end
        smp();
        check("t2_full", 64'(cmd_ready), 64'd0);
        check("t2_req", 64'(req), 64'd1);
        check("t2_no_issue", 64'(mem_en), 64'd0);
        step();
        cmd_valid = 1'b1; cmd_we = 1'b1;
        cmd_addr = 16'h01FF; cmd_wdata = 32'hDEAD_BEEF;
        smp();
        check("t2_stall", 64'(cmd_ready), 64'd0);
        step();
        cmd_valid = 1'b0;
        gnt_drv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("t2_mem_en", 64'(mem_en), 64'd1);
            check("t2_mem_we", 64'(mem_we), 64'd1);
            check("t2_mem_addr", 64'(mem_addr), 64'(16'h0100 + i));
            check("t2_mem_wdata", 64'(mem_wdata), 64'(32'hA000_0000 + i));
            step();
        end
        smp();
        check("t2_drain_en", 64'(mem_en), 64'd0);
        check("t2_drain_req", 64'(req), 64'd0);
        check("t2_drain_ready", 64'(cmd_ready), 64'd1);

        // Spurious grant with nothing queued.
        for (int i = 0; i < 3; i++) begin
            step(); smp();
            check("t4_mem_en", 64'(mem_en), 64'd0);
            check("t4_req", 64'(req), 64'd0);
            check("t4_ready", 64'(cmd_ready), 64'd1);
        end
        step();
        gnt_drv = 1'b0;

        // Sparse grants from a 16-port rotation.
        base = rsp_cnt;
        gnt_rot = 1'b1;
        for (int i = 1; i <= 4; i++) push(1'b0, AW'(i), '0);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("t3_drained", 64'(exp_q.size()), 64'd0);
        check("t3_rsp_count", 64'(rsp_cnt - base), 64'd4);
        gnt_rot = 1'b0;
        step();

        // Reset with two reads in flight and two queued.
        for (int i = 0; i < 4; i++) push(1'b0, AW'(16'h0020 + i), '0);
        gnt_drv = 1'b1;
        step();
        rst = 1'b1;
        exp_q.delete();
        base = rsp_cnt;
        step();
        rst = 1'b0;
        gnt_drv = 1'b0;
        smp();
        check("t5_req", 64'(req), 64'd0);
        check("t5_ready", 64'(cmd_ready), 64'd1);
        check("t5_mem_en", 64'(mem_en), 64'd0);
        repeat (6) begin
            step(); smp();
        end
        check("t5_no_rsp", 64'(rsp_cnt - base), 64'd0);
        step();

`ifdef MEM_CLIENT_TIMEOUT_EN
        push(1'b1, 16'h0030, 32'h5);
        smp();
        for (int k = 1; k < 63; k++) begin
            step(); smp();
        end
        check("t6_err_c63", 64'(timeout_err), 64'd0);
        check("t6_req_c63", 64'(req), 64'd1);
        step(); smp();
        check("t6_err_c64", 64'(timeout_err), 64'd1);
        step();
        gnt_drv = 1'b1;
        smp();
        check("t6_gnt_issue", 64'(mem_en), 64'd1);
        check("t6_err_gnt", 64'(timeout_err), 64'd1);
        step();
        gnt_drv = 1'b0;
        smp();
        check("t6_err_sticky", 64'(timeout_err), 64'd1);
        check("t6_req_done", 64'(req), 64'd0);
`else
        push(1'b1, 16'h0030, 32'h5);
        repeat (70) step();
        smp();
        check("t6_err_off", 64'(timeout_err), 64'd0);
        check("t6_req_held", 64'(req), 64'd1);
        step();
        gnt_drv = 1'b1;
        step();
        gnt_drv = 1'b0;
        smp();
        check("t6_req_done", 64'(req), 64'd0);
`endif
        step();
        check("final_exp_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
